// File: rtl/bm_poly_ibm_if.sv
// Syndrome-in / locator-out handshake bundle for bm_poly_ibm.
// master drives syndromes and takes results; slave is the locator finder.
interface bm_poly_ibm_if #(
    parameter int WORD_WIDTH = 4,
    parameter int NUM_NK     = 6,
    parameter int T_CAP      = NUM_NK / 2
);
    localparam int LEN_W = $clog2(NUM_NK + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] syndrom [NUM_NK];
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] poly_err [T_CAP+1];
    logic [LEN_W-1:0]      err_len;
    logic                  fail;

    modport master (
        output in_valid, syndrom, out_ready,
        input  in_ready, out_valid, poly_err, err_len, fail
    );

    modport slave (
        input  in_valid, syndrom, out_ready,
        output in_ready, out_valid, poly_err, err_len, fail
    );
endinterface

// File: rtl/bm_poly_ibm.sv
// Inversionless Berlekamp-Massey error-locator finder over GF(2^WORD_WIDTH).
// Optional macro ZERO_SYN_BYPASS_EN: all-zero syndrome blocks skip the iterations.
module bm_poly_ibm #(
    parameter int                  WORD_WIDTH = 4,
    parameter logic [WORD_WIDTH:0] PRIM_POLY  = 5'h13,
    parameter int                  NUM_NK     = 6,
    parameter int                  T_CAP      = NUM_NK / 2
) (
    input  logic         clk,
    input  logic         rst_n,
    bm_poly_ibm_if.slave bus
);
    localparam int LEN_W = $clog2(NUM_NK + 1);
    localparam int R_W   = $clog2(NUM_NK);

    typedef enum logic [1:0] {IDLE, DELTA, UPDATE, DONE} state_t;

    state_t                state;
    logic [R_W-1:0]        r;
    logic [LEN_W-1:0]      len;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  fail_q;
    logic [LEN_W-1:0]      err_len_q;
    logic [WORD_WIDTH-1:0] poly_err_q [T_CAP+1];

    logic [WORD_WIDTH-1:0] lam      [NUM_NK+1];
    logic [WORD_WIDTH-1:0] lam_next [NUM_NK+1];
    logic [WORD_WIDTH-1:0] bpoly    [NUM_NK+1];
    logic [WORD_WIDTH-1:0] sw       [NUM_NK];
    logic [WORD_WIDTH-1:0] syn_q    [NUM_NK-1];
    logic [WORD_WIDTH-1:0] gamma;
    logic [WORD_WIDTH-1:0] delta_c;
    logic [WORD_WIDTH-1:0] delta_p1;
    logic                  accept;
    logic                  swap;
    logic                  skip_iter;
    logic                  fail_c;
    int                    deg_c;

    function automatic logic [WORD_WIDTH-1:0] gf_mul(input logic [WORD_WIDTH-1:0] a,
                                                     input logic [WORD_WIDTH-1:0] b);
        logic [WORD_WIDTH-1:0] acc;
        logic [WORD_WIDTH-1:0] sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < WORD_WIDTH; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = sh[WORD_WIDTH-1] ? ((sh << 1) ^ PRIM_POLY[WORD_WIDTH-1:0]) : (sh << 1);
        end
        return acc;
    endfunction

    assign accept = (state == IDLE) && in_ready_q && bus.in_valid;
    assign swap   = (delta_p1 != '0) && ((2 * int'(len)) <= int'(r));

`ifdef ZERO_SYN_BYPASS_EN
    always_comb begin
        skip_iter = 1'b1;
        for (int i = 0; i < NUM_NK; i++)
            if (bus.syndrom[i] != '0) skip_iter = 1'b0;
    end
`else
    assign skip_iter = 1'b0;
`endif

    // sw[i] holds S(r-i), so the discrepancy is a plain dot product with Lambda
    always_comb begin
        delta_c = '0;
        for (int i = 0; i < NUM_NK; i++)
            delta_c = delta_c ^ gf_mul(lam[i], sw[i]);
    end

    always_comb begin
        lam_next[0] = gf_mul(gamma, lam[0]);
        for (int i = 1; i <= NUM_NK; i++)
            lam_next[i] = gf_mul(gamma, lam[i]) ^ gf_mul(delta_p1, bpoly[i-1]);
    end

    always_comb begin
        deg_c = 0;
        for (int i = 0; i <= NUM_NK; i++)
            if (lam[i] != '0) deg_c = i;
        fail_c = (int'(len) > T_CAP) || (deg_c != int'(len)) || (lam[0] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            len         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            fail_q      <= 1'b0;
            err_len_q   <= '0;
            for (int i = 0; i <= T_CAP; i++) poly_err_q[i] <= '0;
            poly_err_q[0] <= WORD_WIDTH'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (!in_ready_q) begin
                        in_ready_q <= 1'b1;
                    end else if (accept) begin
                        in_ready_q <= 1'b0;
                        r          <= '0;
                        len        <= '0;
                        state      <= skip_iter ? DONE : DELTA;
                    end
                end
                DELTA: state <= UPDATE;
                UPDATE: begin
                    if (swap) len <= LEN_W'(int'(r) + 1 - int'(len));
                    if (r == R_W'(NUM_NK - 1)) begin
                        state <= DONE;
                    end else begin
                        r     <= r + R_W'(1);
                        state <= DELTA;
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        for (int i = 0; i <= T_CAP; i++) poly_err_q[i] <= lam[i];
                        err_len_q   <= len;
                        fail_q      <= fail_c;
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            // accept: load syndrome window and reset the polynomials
            IDLE: begin
                if (accept) begin
                    for (int i = 0; i < NUM_NK; i++) sw[i] <= '0;
                    sw[0] <= bus.syndrom[0];
                    for (int i = 0; i < NUM_NK - 1; i++) syn_q[i] <= bus.syndrom[i+1];
                    for (int i = 0; i <= NUM_NK; i++) begin
                        lam[i]   <= '0;
                        bpoly[i] <= '0;
                    end
                    lam[0]   <= WORD_WIDTH'(1);
                    bpoly[0] <= WORD_WIDTH'(1);
                    gamma    <= WORD_WIDTH'(1);
                end
            end
            // DELTA -> UPDATE boundary
            DELTA: delta_p1 <= delta_c;
            UPDATE: begin
                lam <= lam_next;
                if (swap) begin
                    bpoly <= lam;
                    gamma <= delta_p1;
                end else begin
                    bpoly[0] <= '0;
                    for (int i = 1; i <= NUM_NK; i++) bpoly[i] <= bpoly[i-1];
                end
                sw[0] <= syn_q[0];
                for (int i = 1; i < NUM_NK; i++) sw[i] <= sw[i-1];
                for (int i = 0; i < NUM_NK - 2; i++) syn_q[i] <= syn_q[i+1];
                syn_q[NUM_NK-2] <= '0;
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.poly_err  = poly_err_q;
    assign bus.err_len   = err_len_q;
    assign bus.fail      = fail_q;
endmodule

// File: tb/tb_bm_poly_ibm.sv
// Self-checking bench for bm_poly_ibm: table-driven GF(16) arithmetic and a
// textbook (normalised) Berlekamp-Massey reference model.
module tb_bm_poly_ibm;
    localparam int WW = 4;
    localparam int NK = 6;
    localparam int TC = NK / 2;
    localparam int Q  = (1 << WW) - 1;
    localparam logic [WW:0] PP = 5'h13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bm_poly_ibm_if #(.WORD_WIDTH(WW), .NUM_NK(NK), .T_CAP(TC)) bus ();
    bm_poly_ibm #(.WORD_WIDTH(WW), .PRIM_POLY(PP), .NUM_NK(NK), .T_CAP(TC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int gexp [Q];
    int glog [Q+1];
    logic [WW-1:0] cur_syn [NK];
    int err_pos [4];
    int err_val [4];
    int n_err;
    int mdl_c [2*NK+2];
    int mdl_l, mdl_fail;
    int dut_raw [TC+1];
    int dut_norm [TC+1];
    int dut_len, dut_fail;
    logic acc_ok;

    function automatic int gmul(int a, int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % Q];
    endfunction

    function automatic int ginv(int a);
        return gexp[(Q - glog[a]) % Q];
    endfunction

    function automatic int apow(int n);
        return gexp[n % Q];
    endfunction

    function automatic int exp_lat();
        int lat;
        lat = 2 * NK + 1;
`ifdef ZERO_SYN_BYPASS_EN
        lat = 1;
        for (int j = 0; j < NK; j++) if (cur_syn[j] != '0) lat = 2 * NK + 1;
`endif
        return lat;
    endfunction

    task automatic build_tables();
        int e;
        e = 1;
        glog[0] = 0;
        for (int k = 0; k < Q; k++) begin
            gexp[k] = e;
            glog[e] = k;
            e = e << 1;
            if (e > Q) e = e ^ int'(PP);
        end
    endtask

    // Sj = sum over errors of value * X^(j+1), X = alpha^position
    task automatic make_syn();
        int s;
        for (int j = 0; j < NK; j++) begin
            s = 0;
            for (int e = 0; e < n_err; e++) s = s ^ gmul(err_val[e], apow(err_pos[e] * (j + 1)));
            cur_syn[j] = WW'(s);
        end
    endtask

    task automatic model_bm();
        int c [2*NK+2];
        int b [2*NK+2];
        int t [2*NK+2];
        int L, m, bb, d, coef, deg;
        for (int i = 0; i < 2*NK+2; i++) begin c[i] = 0; b[i] = 0; end
        c[0] = 1; b[0] = 1; L = 0; m = 1; bb = 1;
        for (int n = 0; n < NK; n++) begin
            d = int'(cur_syn[n]);
            for (int i = 1; i <= L; i++) if (n - i >= 0) d = d ^ gmul(c[i], int'(cur_syn[n-i]));
            if (d == 0) begin
                m++;
            end else begin
                coef = gmul(d, ginv(bb));
                t = c;
                for (int i = 0; i + m < 2*NK+2; i++) c[i+m] = c[i+m] ^ gmul(coef, b[i]);
                if (2 * L <= n) begin
                    L = n + 1 - L; b = t; bb = d; m = 1;
                end else begin
                    m++;
                end
            end
        end
        deg = 0;
        for (int i = 0; i < 2*NK+2; i++) if (c[i] != 0) deg = i;
        mdl_c = c;
        mdl_l = L;
        mdl_fail = (L > TC || deg != L) ? 1 : 0;
    endtask

    task automatic capture();
        int inv;
        dut_len  = int'(bus.err_len);
        dut_fail = int'(bus.fail);
        inv = (bus.poly_err[0] != '0) ? ginv(int'(bus.poly_err[0])) : 1;
        for (int i = 0; i <= TC; i++) begin
            dut_raw[i]  = int'(bus.poly_err[i]);
            dut_norm[i] = gmul(dut_raw[i], inv);
        end
    endtask

    task automatic start_block();
        bus.syndrom  = cur_syn;
        bus.in_valid = 1'b1;
        acc_ok = 1'b0;
        for (int k = 0; k < 60 && !acc_ok; k++) begin
            if (bus.in_ready) acc_ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        if (!acc_ok) begin
            lat = -1;
            return;
        end
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        for (int j = 0; j < NK; j++) bus.syndrom[j] = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b want=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.err_len !== '0) begin failures++; $display("FAIL reset_err_len got=%0d want=0", bus.err_len); end
        checks++; if (bus.fail !== 1'b0) begin failures++; $display("FAIL reset_fail got=%0b want=0", bus.fail); end
        for (int i = 0; i <= TC; i++) begin
            checks++; if (int'(bus.poly_err[i]) !== ((i == 0) ? 1 : 0)) begin failures++; $display("FAIL reset_poly[%0d] got=%0h want=%0h", i, bus.poly_err[i], (i == 0) ? 1 : 0); end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b want=1", bus.in_ready); end
    endtask

    task automatic test_zero();
        int lat;
        for (int j = 0; j < NK; j++) cur_syn[j] = '0;
        bus.out_ready = 1'b1;
        start_block();
        wait_out(lat);
        capture();
        checks++; if (lat !== exp_lat()) begin failures++; $display("FAIL zero_latency got=%0d want=%0d", lat, exp_lat()); end
        for (int i = 0; i <= TC; i++) begin
            checks++; if (dut_raw[i] !== ((i == 0) ? 1 : 0)) begin failures++; $display("FAIL zero_poly[%0d] got=%0h want=%0h", i, dut_raw[i], (i == 0) ? 1 : 0); end
        end
        checks++; if (dut_len !== 0) begin failures++; $display("FAIL zero_err_len got=%0d want=0", dut_len); end
        checks++; if (dut_fail !== 0) begin failures++; $display("FAIL zero_fail got=%0d want=0", dut_fail); end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL zero_taken out_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL zero_bubble in_ready got=%0b want=1", bus.in_ready); end
    endtask

    task automatic test_single();
        int lat;
        n_err = 1; err_pos[0] = 5; err_val[0] = 1;
        make_syn();
        start_block();
        wait_out(lat);
        capture();
        checks++; if (lat !== 2*NK+1) begin failures++; $display("FAIL single_latency got=%0d want=%0d", lat, 2*NK+1); end
        checks++; if (dut_len !== 1) begin failures++; $display("FAIL single_err_len got=%0d want=1", dut_len); end
        checks++; if (dut_fail !== 0) begin failures++; $display("FAIL single_fail got=%0d want=0", dut_fail); end
        checks++; if (dut_raw[2] !== 0 || dut_raw[3] !== 0) begin failures++; $display("FAIL single_high got=%0h,%0h want=0,0", dut_raw[2], dut_raw[3]); end
        checks++; if (dut_raw[0] == 0 || dut_raw[1] !== gmul(6, dut_raw[0])) begin failures++; $display("FAIL single_ratio got=%0h want=%0h", dut_raw[1], gmul(6, dut_raw[0])); end
        take();
    endtask

    task automatic test_two();
        int lat, v, rt, xp;
        n_err = 2; err_pos[0] = 2; err_pos[1] = 7; err_val[0] = 1; err_val[1] = 1;
        make_syn();
        model_bm();
        start_block();
        wait_out(lat);
        capture();
        checks++; if (lat !== 2*NK+1) begin failures++; $display("FAIL two_latency got=%0d want=%0d", lat, 2*NK+1); end
        checks++; if (dut_len !== 2) begin failures++; $display("FAIL two_err_len got=%0d want=2", dut_len); end
        checks++; if (dut_fail !== 0) begin failures++; $display("FAIL two_fail got=%0d want=0", dut_fail); end
        for (int i = 0; i <= TC; i++) begin
            checks++; if (dut_norm[i] !== mdl_c[i]) begin failures++; $display("FAIL two_norm[%0d] got=%0h want=%0h", i, dut_norm[i], mdl_c[i]); end
        end
        for (int k = 0; k < 2; k++) begin
            rt = apow(Q - err_pos[k]);
            v = 0; xp = 1;
            for (int i = 0; i <= TC; i++) begin
                v = v ^ gmul(dut_norm[i], xp);
                xp = gmul(xp, rt);
            end
            checks++; if (v !== 0) begin failures++; $display("FAIL two_root_a^-%0d got=%0h want=0", err_pos[k], v); end
        end
        take();
    endtask

    task automatic test_four();
        int lat;
        n_err = 4;
        err_pos[0] = 1; err_pos[1] = 3; err_pos[2] = 8; err_pos[3] = 12;
        for (int e = 0; e < 4; e++) err_val[e] = 1;
        make_syn();
        model_bm();
        start_block();
        wait_out(lat);
        capture();
        checks++; if (lat !== 2*NK+1) begin failures++; $display("FAIL four_latency got=%0d want=%0d", lat, 2*NK+1); end
        checks++; if (dut_fail !== mdl_fail) begin failures++; $display("FAIL four_fail got=%0d want=%0d", dut_fail, mdl_fail); end
        checks++; if (dut_len !== mdl_l) begin failures++; $display("FAIL four_err_len got=%0d want=%0d", dut_len, mdl_l); end
        for (int i = 0; i <= TC; i++) begin
            checks++; if (dut_norm[i] !== mdl_c[i]) begin failures++; $display("FAIL four_norm[%0d] got=%0h want=%0h", i, dut_norm[i], mdl_c[i]); end
        end
        take();
    endtask

    task automatic test_random();
        int lat, p, dup, hold;
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                for (int j = 0; j < NK; j++) cur_syn[j] = WW'($urandom_range(0, Q));
            end else begin
                n_err = $urandom_range(0, 4);
                for (int e = 0; e < n_err; e++) begin
                    do begin
                        p = $urandom_range(0, Q - 1);
                        dup = 0;
                        for (int f = 0; f < e; f++) if (err_pos[f] == p) dup = 1;
                    end while (dup != 0);
                    err_pos[e] = p;
                    err_val[e] = $urandom_range(1, Q);
                end
                make_syn();
            end
            model_bm();
            start_block();
            wait_out(lat);
            capture();
            checks++; if (lat !== exp_lat()) begin failures++; $display("FAIL rand%0d_latency got=%0d want=%0d", it, lat, exp_lat()); end
            checks++; if (dut_len !== mdl_l) begin failures++; $display("FAIL rand%0d_err_len got=%0d want=%0d", it, dut_len, mdl_l); end
            checks++; if (dut_fail !== mdl_fail) begin failures++; $display("FAIL rand%0d_fail got=%0d want=%0d", it, dut_fail, mdl_fail); end
            for (int i = 0; i <= TC; i++) begin
                checks++; if (dut_norm[i] !== mdl_c[i]) begin failures++; $display("FAIL rand%0d_norm[%0d] got=%0h want=%0h", it, i, dut_norm[i], mdl_c[i]); end
            end
            hold = $urandom_range(0, 3);
            repeat (hold) begin @(posedge clk); #1; end
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rand%0d_hold out_valid got=%0b want=1", it, bus.out_valid); end
            take();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int rec_poly [TC+1];
        int rec_len;
        n_err = 1; err_pos[0] = 5; err_val[0] = 1;
        make_syn();
        start_block();
        wait_out(lat);
        capture();
        rec_poly = dut_raw;
        rec_len = dut_len;
        checks++; if (rec_len !== 1) begin failures++; $display("FAIL bp_first_len got=%0d want=1", rec_len); end
        n_err = 2; err_pos[0] = 4; err_pos[1] = 11; err_val[0] = 3; err_val[1] = 9;
        make_syn();
        model_bm();
        bus.syndrom  = cur_syn;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold%0d out_valid got=%0b want=1", c, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d in_ready got=%0b want=0", c, bus.in_ready); end
            checks++; if (int'(bus.err_len) !== rec_len) begin failures++; $display("FAIL bp_hold%0d err_len got=%0d want=%0d", c, bus.err_len, rec_len); end
            for (int i = 0; i <= TC; i++) begin
                checks++; if (int'(bus.poly_err[i]) !== rec_poly[i]) begin failures++; $display("FAIL bp_hold%0d poly[%0d] got=%0h want=%0h", c, i, bus.poly_err[i], rec_poly[i]); end
            end
        end
        take();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_taken out_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_bubble in_ready got=%0b want=1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_accept in_ready got=%0b want=0", bus.in_ready); end
        acc_ok = 1'b1;
        wait_out(lat);
        capture();
        checks++; if (lat !== 2*NK+1) begin failures++; $display("FAIL bp_next_latency got=%0d want=%0d", lat, 2*NK+1); end
        checks++; if (dut_len !== mdl_l) begin failures++; $display("FAIL bp_next_err_len got=%0d want=%0d", dut_len, mdl_l); end
        checks++; if (dut_fail !== mdl_fail) begin failures++; $display("FAIL bp_next_fail got=%0d want=%0d", dut_fail, mdl_fail); end
        for (int i = 0; i <= TC; i++) begin
            checks++; if (dut_norm[i] !== mdl_c[i]) begin failures++; $display("FAIL bp_next_norm[%0d] got=%0h want=%0h", i, dut_norm[i], mdl_c[i]); end
        end
        take();
    endtask

    task automatic test_midreset();
        int seen;
        n_err = 1; err_pos[0] = 5; err_val[0] = 1;
        make_syn();
        bus.out_ready = 1'b1;
        start_block();
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mrst_out_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mrst_in_ready got=%0b want=0", bus.in_ready); end
        checks++; if (bus.err_len !== '0) begin failures++; $display("FAIL mrst_err_len got=%0d want=0", bus.err_len); end
        for (int i = 0; i <= TC; i++) begin
            checks++; if (int'(bus.poly_err[i]) !== ((i == 0) ? 1 : 0)) begin failures++; $display("FAIL mrst_poly[%0d] got=%0h want=%0h", i, bus.poly_err[i], (i == 0) ? 1 : 0); end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mrst_release in_ready got=%0b want=1", bus.in_ready); end
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mrst_stale_out_valid cycles=%0d want=0", seen); end
        bus.out_ready = 1'b0;
        test_single();
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        build_tables();
        test_reset();
        test_zero();
        test_single();
        test_two();
        test_four();
        test_random();
        test_back_to_back();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
